// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: op codes, sequencer states and
// the bit positions of the {c, v, n, z} flag vector.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ZERO = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_LSL  = 4'b0011,
        OP_LSR  = 4'b0100,
        OP_ROL  = 4'b0101,
        OP_ROR  = 4'b0110,
        OP_AND  = 4'b0111,
        OP_OR   = 4'b1000,
        OP_XOR  = 4'b1001,
        OP_NOT  = 4'b1010,
        OP_CLR  = 4'b1011,
        OP_ADC  = 4'b1100,
        OP_SBC  = 4'b1101,
        OP_ASR  = 4'b1110,
        OP_MUL  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: result, carry/borrow and signed
// overflow for every op except multiply (which the sequencer handles).
import alu_pkg::*;

module alu_core #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  alu_op_t          op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [SHW-1:0]          sh;
    logic                    cin_add;
    logic                    cin_sub;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic [WIDTH:0]          lsl_ext;
    logic [WIDTH:0]          lsr_ext;
    logic signed [WIDTH:0]   asr_src;
    logic signed [WIDTH:0]   asr_ext;
    int unsigned             rot_amt;

    assign sh      = b[SHW-1:0];
    assign cin_add = (op == OP_ADC) ? cin : 1'b0;
    assign cin_sub = (op == OP_SBC) ? cin : 1'b0;
    assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_add};
    assign diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_sub};

    // Shifts run one bit wider than the datapath so the extra bit is the
    // last bit shifted out; with sh=0 that bit is the zero padding.
    assign lsl_ext = {1'b0, a} << sh;
    assign lsr_ext = {a, 1'b0} >> sh;
    assign asr_src = {a, 1'b0};
    assign asr_ext = asr_src >>> sh;
    assign rot_amt = 32'(sh) % WIDTH;

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_LSL: begin
                result = lsl_ext[WIDTH-1:0];
                carry  = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                result = lsr_ext[WIDTH:1];
                carry  = lsr_ext[0];
            end
            OP_ASR: begin
                result = asr_ext[WIDTH:1];
                carry  = asr_ext[0];
            end
            OP_ROL:  result = (a << rot_amt) | (a >> (WIDTH - rot_amt));
            OP_ROR:  result = (a >> rot_amt) | (a << (WIDTH - rot_amt));
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, single-cycle ops through
// alu_core and an iterative shift-add multiplier.
import alu_pkg::*;

module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic             cin,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output alu_state_t       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high. Inputs are captured only on that edge; the result is
    // held on out/flags while out_valid=1 until out_ready=1.

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_t           state;
    alu_state_t           state_next;
    alu_op_t              op_in;
    logic                 accept;
    logic                 is_mul;
    logic                 mul_last;
    logic [WIDTH-1:0]     core_result;
    logic                 core_carry;
    logic                 core_overflow;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    assign op_in     = alu_op_t'(alu_op);
    assign is_mul    = (op_in == OP_MUL);
    assign accept    = in_valid & in_ready;
    // cnt 0..WIDTH-1 are the iterations; cnt==WIDTH is the writeback cycle.
    assign mul_last  = (state == MUL) && (cnt == CW'(WIDTH));
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .op       (op_in),
        .cin      (cin),
        .a        (input_A),
        .b        (input_B),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_overflow)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = is_mul ? MUL : DONE;
            end
            MUL: begin
                if (mul_last) state_next = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_next = in_valid ? (is_mul ? MUL : DONE) : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out    <= '0;
            flags  <= 4'b0001;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= {{WIDTH{1'b0}}, input_A};
                mplier <= input_B;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                out           <= core_result;
                flags[FLAG_C] <= core_carry;
                flags[FLAG_V] <= core_overflow;
                flags[FLAG_N] <= core_result[WIDTH-1];
                flags[FLAG_Z] <= (core_result == '0);
            end
        end else if (state == MUL) begin
            if (mul_last) begin
                out           <= acc[WIDTH-1:0];
                flags[FLAG_C] <= |acc[2*WIDTH-1:WIDTH];
                flags[FLAG_V] <= 1'b0;
                flags[FLAG_N] <= acc[WIDTH-1];
                flags[FLAG_Z] <= (acc[WIDTH-1:0] == '0);
            end else begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expectations.
import alu_pkg::*;

module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic        cin;
    logic [7:0]  input_A;
    logic [7:0]  input_B;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out;
    logic [3:0]  flags;
    alu_state_t  dbg_state;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .cin       (cin),
        .input_A   (input_A),
        .input_B   (input_B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: present one op for one edge, then scramble the inputs
    task automatic drive_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic rdy);
        alu_op    = op;
        input_A   = a;
        input_B   = b;
        cin       = c;
        out_ready = rdy;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        alu_op    = 4'($urandom_range(0, 15));
        input_A   = 8'($urandom_range(0, 255));
        input_B   = 8'($urandom_range(0, 255));
        cin       = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 4'd0; cin = 1'b0; input_A = 8'd0; input_B = 8'd0;
        #1;
        checks++;
        if ({out_valid, out, flags} !== {1'b0, 8'h00, 4'b0001}) begin
            $display("FAIL reset_outputs: got v=%b out=%h flags=%b want v=0 out=00 flags=0001",
                     out_valid, out, flags);
            errors++;
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, dbg_state} !== {1'b1, IDLE}) begin
            $display("FAIL reset_ready: got in_ready=%b state=%0d want 1/IDLE", in_ready, dbg_state);
            errors++;
        end
    endtask

    task automatic test_add();
        drive_op(4'b0001, 8'h7F, 8'h01, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out, flags} !== {1'b1, 8'h80, 4'b0110}) begin
            $display("FAIL add_7f_01: got v=%b out=%h flags=%b want v=1 out=80 flags=0110",
                     out_valid, out, flags);
            errors++;
        end
        drive_op(4'b0001, 8'hFF, 8'h01, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out, flags} !== {1'b1, 8'h00, 4'b1001}) begin
            $display("FAIL add_ff_01: got v=%b out=%h flags=%b want v=1 out=00 flags=1001",
                     out_valid, out, flags);
            errors++;
        end
        drive_op(4'b1100, 8'hFF, 8'h00, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out, flags} !== {1'b1, 8'h00, 4'b1001}) begin
            $display("FAIL adc_ff_00_c1: got v=%b out=%h flags=%b want v=1 out=00 flags=1001",
                     out_valid, out, flags);
            errors++;
        end
    endtask

    task automatic test_sub();
        drive_op(4'b1101, 8'h10, 8'h10, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out, flags} !== {1'b1, 8'hFF, 4'b1010}) begin
            $display("FAIL sbc_10_10_c1: got v=%b out=%h flags=%b want v=1 out=ff flags=1010",
                     out_valid, out, flags);
            errors++;
        end
        drive_op(4'b0010, 8'h05, 8'h03, 1'b1, 1'b1);
        checks++;
        if ({out_valid, out, flags} !== {1'b1, 8'h02, 4'b0000}) begin
            $display("FAIL sub_05_03: got v=%b out=%h flags=%b want v=1 out=02 flags=0000",
                     out_valid, out, flags);
            errors++;
        end
    endtask

    task automatic test_reset_mid_mul();
        drive_op(4'b1111, 8'h0F, 8'h0F, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out, flags} !== {1'b0, 8'h00, 4'b0001}) begin
            $display("FAIL reset_mid_mul: got v=%b out=%h flags=%b want v=0 out=00 flags=0001",
                     out_valid, out, flags);
            errors++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, dbg_state} !== {1'b1, IDLE}) begin
            $display("FAIL reset_mid_mul_ready: got in_ready=%b state=%0d want 1/IDLE",
                     in_ready, dbg_state);
            errors++;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({out_valid, out} !== {1'b0, 8'h00}) begin
            $display("FAIL reset_mid_mul_no_resume: got v=%b out=%h want v=0 out=00", out_valid, out);
            errors++;
        end
    endtask

    task automatic test_shifts();
        drive_op(4'b0011, 8'h81, 8'h01, 1'b0, 1'b1);
        checks++;
        if ({out, flags} !== {8'h02, 4'b1000}) begin
            $display("FAIL lsl_81_1: got out=%h flags=%b want out=02 flags=1000", out, flags);
            errors++;
        end
        drive_op(4'b1110, 8'h80, 8'h03, 1'b0, 1'b1);
        checks++;
        if ({out, flags} !== {8'hF0, 4'b0010}) begin
            $display("FAIL asr_80_3: got out=%h flags=%b want out=f0 flags=0010", out, flags);
            errors++;
        end
        drive_op(4'b0100, 8'h81, 8'h00, 1'b0, 1'b1);
        checks++;
        if ({out, flags} !== {8'h81, 4'b0010}) begin
            $display("FAIL lsr_81_0: got out=%h flags=%b want out=81 flags=0010", out, flags);
            errors++;
        end
        drive_op(4'b0101, 8'h81, 8'h01, 1'b0, 1'b1);
        checks++;
        if ({out, flags} !== {8'h03, 4'b0000}) begin
            $display("FAIL rol_81_1: got out=%h flags=%b want out=03 flags=0000", out, flags);
            errors++;
        end
        drive_op(4'b0110, 8'h01, 8'h09, 1'b0, 1'b1);
        checks++;
        if ({out, flags} !== {8'h80, 4'b0010}) begin
            $display("FAIL ror_01_9: got out=%h flags=%b want out=80 flags=0010", out, flags);
            errors++;
        end
    endtask

    task automatic test_mul();
        int lat;
        bit busy_bad;
        busy_bad = 1'b0;
        drive_op(4'b1111, 8'h10, 8'h10, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (busy_bad) begin
            $display("FAIL mul_busy: out_valid/in_ready not both 0 during multiply");
            errors++;
        end
        checks++;
        if ({out_valid, out, flags} !== {1'b1, 8'h00, 4'b1001}) begin
            $display("FAIL mul_10_10: got v=%b out=%h flags=%b want v=1 out=00 flags=1001 at +9",
                     out_valid, out, flags);
            errors++;
        end
        @(posedge clk); #1;
        drive_op(4'b1111, 8'h0C, 8'h0B, 1'b0, 1'b1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if ({lat, out, flags} !== {32'd9, 8'h84, 4'b0010}) begin
            $display("FAIL mul_0c_0b: got lat=%0d out=%h flags=%b want lat=9 out=84 flags=0010",
                     lat, out, flags);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        bit hold_bad;
        hold_bad = 1'b0;
        @(posedge clk); #1;
        drive_op(4'b0001, 8'h01, 8'h02, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if ({out_valid, in_ready, out, flags} !== {1'b1, 1'b0, 8'h03, 4'b0000}) hold_bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (hold_bad || {out_valid, out} !== {1'b1, 8'h03}) begin
            $display("FAIL backpressure_hold: got v=%b out=%h want v=1 out=03 stable, in_ready=0",
                     out_valid, out);
            errors++;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL done_ready: got in_ready=%b want 1 with out_ready=1", in_ready);
            errors++;
        end
        drive_op(4'b1001, 8'hF0, 8'hFF, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out, flags} !== {1'b1, 8'h0F, 4'b0000}) begin
            $display("FAIL back_to_back_xor: got v=%b out=%h flags=%b want v=1 out=0f flags=0000",
                     out_valid, out, flags);
            errors++;
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out, dbg_state} !== {1'b0, 8'h0F, IDLE}) begin
            $display("FAIL consume_once: got v=%b out=%h state=%0d want v=0 out=0f IDLE",
                     out_valid, out, dbg_state);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_reset_mid_mul();
        test_shifts();
        test_mul();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
